autoscale_bfp: RTL
==================

Name: autoscale_bfp

Overview:
- Multi-channel autoscaler with optional block-floating-point (BFP) mode.
- Finds one common left shift for NCH channels so that the largest magnitude fills DIN_WIDTH-1 bits, keeping one headroom bit, and applies it to every channel.
- Per-sample mode: the shift is computed and applied to the same sample.
- Frame mode: the shift is taken from the previous FRAME_LEN-sample frame and held for the whole current frame. The shift is reported so downstream exponent tracking (arctan/DoA datapath) stays consistent.

Parameters:
- NCH, 4, number of channels sharing one shift
- DIN_WIDTH, 32, bits per channel sample
- MAX_SHIFT, 10, upper clamp on applied shift
- SIGNED, 0, 1 = two's-complement channel data, 0 = unsigned
- FRAME_LEN, 64, valid samples per frame in frame mode (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- din  in  NCH*DIN_WIDTH  channel samples; channel i at [i*DIN_WIDTH +: DIN_WIDTH]
- din_valid  in  1  sample qualifier
- frame_mode  in  1  0 = per-sample shift, 1 = held frame shift; sampled with din
- dout  out  NCH*DIN_WIDTH  scaled samples, same packing as din
- dout_shift  out  $clog2(MAX_SHIFT+1)  shift applied to this dout
- dout_sat  out  1  at least one channel saturated on this sample
- dout_valid  out  1  output qualifier

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: dout=0, dout_shift=0, dout_sat=0, dout_valid=0. Pipeline valids, frame counter, accumulated OR and held shift are all cleared.
- Reset mid-frame: any sample in flight is discarded (no dout_valid). The next valid sample starts a new frame 0 with held shift 0.
- Latency: fixed 3 cycles from din_valid to dout_valid, in both modes. The bubble pattern is preserved. No backpressure.
- Stage 1, register inputs and compute magnitude word per channel:
  - SIGNED=1: mag = x XOR {DIN_WIDTH{x[msb]}}, i.e. one's complement, so no abs overflow.
  - SIGNED=0: mag = x.
  - idx = OR of all channel mags.
- Stage 2, leading-one search:
  - p = position of the highest set bit of idx.
  - raw shift = DIN_WIDTH-2-p.
  - p = DIN_WIDTH-1 (unsigned only) gives raw 0.
  - idx = 0 gives raw MAX_SHIFT.
  - sample_shift = min(raw, MAX_SHIFT).
- Stage 3, shift and output:
  - applied shift = sample_shift when frame_mode=1'b0 for that sample, else held_shift.
  - Arithmetic left shift with zero fill.
- Saturation:
  - Per-sample mode never saturates by construction.
  - Frame mode can overflow when a later frame is larger than the one that set the shift.
  - SIGNED=1: clamp to 0x7F..F / 0x80..0.
  - SIGNED=0: clamp to 0xFF..F.
  - dout_sat=1 for that output sample if any channel clamped.
- Frame counter:
  - Counts valid samples 0..FRAME_LEN-1 and wraps.
  - Runs in both modes, so switching mode does not re-align frames.
  - din_valid low does not advance it.
- Accumulator:
  - acc |= idx on each valid sample.
  - On the sample with count = FRAME_LEN-1: held_shift <= clamp(shift of (acc | idx)) and acc <= 0 in the same cycle. The last sample's idx is included, not lost.
  - The new held_shift first applies to sample 0 of the next frame. Samples of the first frame after reset use held_shift=0.
- Mode switch: takes effect on the exact sample where frame_mode changes. It is carried down the pipeline with the data.

Test Plan (NCH=2, DIN_WIDTH=16, MAX_SHIFT=10, FRAME_LEN=4 unless stated):
- Per-sample, unsigned: din ch0=0x0010, ch1=0x0003 (idx=0x0013, p=4) -> 3 cycles later dout ch0=0x4000, ch1=0x0C00, shift=10, sat=0.
- Clamp and zero: ch0=ch1=0x0000 -> dout 0, shift=10. Then ch0=0x0001, ch1=0 -> shift clamps 14->10, dout ch0=0x0400. Then ch0=0x4000 -> shift 0, dout unchanged.
- Signed (SIGNED=1): ch0=0xFFF0 (-16), ch1=0x0005 -> mag OR=0x000F, shift=10 -> dout ch0=0xC000 (-16384), ch1=0x1400.
- Frame mode:
  - Frame 0 = four samples, max 0x0100 -> outputs of frame 0 pass unshifted, shift=0.
  - Frame 1 first sample 0x0040 -> 0x1000, shift=6.
  - Frame 1 sample 0x0800 -> 0xFFFF unsigned, sat=1.
- Valid gaps and timing: din_valid pattern 1,0,0,1,1,0,1 -> dout_valid reproduces the same pattern delayed 3 cycles. Frame boundary falls after the 4th valid sample, not the 4th cycle.
- Reset mid-frame: assert rst for 1 cycle after 2 valid samples of frame 1 (held=6) -> all outputs 0 next cycle, in-flight samples dropped. A frame-mode sample after reset is output with shift=0; held shift updates only after 4 new valid samples.

Source files
------------

// File: rtl/autoscale_bfp.sv
// Multi-channel autoscaler: one common left shift for all channels, either per sample or
// held from the previous frame (block floating point), with saturation and 3-cycle latency.
module autoscale_bfp #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DIN_WIDTH = 32,
  parameter int unsigned MAX_SHIFT = 10,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NCH*DIN_WIDTH-1:0]           din,
  input  logic                               din_valid,
  input  logic                               frame_mode,
  output logic [NCH*DIN_WIDTH-1:0]           dout,
  output logic [$clog2(MAX_SHIFT+1)-1:0]     dout_shift,
  output logic                               dout_sat,
  output logic                               dout_valid
);

  localparam int unsigned W  = DIN_WIDTH;
  localparam int unsigned SW = $clog2(MAX_SHIFT + 1);
  localparam int unsigned CW = $clog2(FRAME_LEN);
  localparam int unsigned EW = W + MAX_SHIFT;

  // Shift that brings the highest set bit of idx to position W-2, clamped to MAX_SHIFT.
  function automatic logic [SW-1:0] calc_shift(input logic [W-1:0] idx);
    int unsigned p;
    int unsigned raw;
    logic        found;
    p     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (idx[i]) begin
        p     = i;
        found = 1'b1;
      end
    end
    if (!found) begin
      raw = MAX_SHIFT;
    end else if (p >= W - 1) begin
      raw = 0;
    end else begin
      raw = W - 2 - p;
    end
    if (raw > MAX_SHIFT) raw = MAX_SHIFT;
    return SW'(raw);
  endfunction

  // Stage 1
  logic [NCH*W-1:0] s1_data_q, s1_data_d;
  logic [W-1:0]     s1_idx_q, s1_idx_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q, s1_mode_d;
  // Stage 2
  logic [NCH*W-1:0] s2_data_q, s2_data_d;
  logic [SW-1:0]    s2_shift_q, s2_shift_d;
  logic             s2_valid_q, s2_valid_d;
  // Frame tracking
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [SW-1:0]    held_q, held_d;
  // Output stage
  logic [NCH*W-1:0] dout_q, dout_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;

  always_comb begin
    logic [W-1:0] x;
    s1_data_d  = din;
    s1_valid_d = din_valid;
    s1_mode_d  = frame_mode;
    s1_idx_d   = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      x = din[ch*W +: W];
      // One's complement for negative values avoids the abs() overflow on the most negative code
      if (SIGNED != 0) x = x ^ {W{x[W-1]}};
      s1_idx_d = s1_idx_d | x;
    end
  end

  always_comb begin
    s2_data_d  = s1_data_q;
    s2_valid_d = s1_valid_q;
    s2_shift_d = s1_mode_q ? held_q : calc_shift(s1_idx_q);
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    held_d     = held_q;
    if (s1_valid_q) begin
      if (cnt_q == CW'(FRAME_LEN - 1)) begin
        // Last sample of the frame is folded in before the held shift is refreshed
        cnt_d  = '0;
        acc_d  = '0;
        held_d = calc_shift(acc_q | s1_idx_q);
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_q | s1_idx_q;
      end
    end
  end

  always_comb begin
    logic [W-1:0]     x;
    logic [EW-1:0]    ext;
    logic [EW-1:0]    sh;
    logic             neg;
    logic             ovf;
    logic [NCH*W-1:0] res;
    logic             any_sat;
    res     = '0;
    any_sat = 1'b0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      x   = s2_data_q[ch*W +: W];
      neg = (SIGNED != 0) && x[W-1];
      ext = {{MAX_SHIFT{neg}}, x};
      sh  = ext << s2_shift_q;
      if (SIGNED != 0) begin
        ovf = !((&sh[EW-1:W-1]) || !(|sh[EW-1:W-1]));
      end else begin
        ovf = |sh[EW-1:W];
      end
      if (ovf) begin
        res[ch*W +: W] = neg ? {1'b1, {(W-1){1'b0}}}
                             : ((SIGNED != 0) ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}});
      end else begin
        res[ch*W +: W] = sh[W-1:0];
      end
      any_sat = any_sat | ovf;
    end
    valid_d = s2_valid_q;
    dout_d  = s2_valid_q ? res : dout_q;
    shift_d = s2_valid_q ? s2_shift_q : shift_q;
    sat_d   = s2_valid_q ? any_sat : sat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_shift_q <= '0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      held_q     <= '0;
      dout_q     <= '0;
      shift_q    <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_idx_q   <= s1_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s2_data_q  <= s2_data_d;
      s2_shift_q <= s2_shift_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      held_q     <= held_d;
      dout_q     <= dout_d;
      shift_q    <= shift_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_shift = shift_q;
  assign dout_sat   = sat_q;
  assign dout_valid = valid_q;

endmodule
